// File: rtl/usb2_ep_pkg.sv
// usb2_ep_pkg: endpoint mode and data-toggle encodings shared by the ring,
// plus the toggle sequencing rule.
// Optional feature macro used elsewhere in this slice: USB2_EP_RING_FLUSH_EN.
package usb2_ep_pkg;

  typedef enum logic [1:0] {
    EP_MODE_CONTROL   = 2'd0,
    EP_MODE_ISOCH     = 2'd1,
    EP_MODE_BULK      = 2'd2,
    EP_MODE_INTERRUPT = 2'd3
  } ep_mode_e;

  typedef enum logic [1:0] {
    DATA_TOGGLE_0 = 2'd0,
    DATA_TOGGLE_1 = 2'd1,
    DATA_TOGGLE_2 = 2'd2,
    DATA_TOGGLE_M = 2'd3
  } data_toggle_e;

  // Isoch cycles DATA0->DATA1->DATA2->DATA0; every other mode alternates
  // DATA0/DATA1, so a leftover DATA2 after a mode switch falls back to DATA0.
  function automatic logic [1:0] next_toggle(input logic [1:0] cur, input logic is_isoch);
    logic [1:0] nxt;
    nxt = DATA_TOGGLE_0;
    if (is_isoch) begin
      if (cur == DATA_TOGGLE_0)      nxt = DATA_TOGGLE_1;
      else if (cur == DATA_TOGGLE_1) nxt = DATA_TOGGLE_2;
    end else if (cur == DATA_TOGGLE_0) begin
      nxt = DATA_TOGGLE_1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/usb2_ep_ring_if.sv
// usb2_ep_ring_if: write side, read side and status/toggle signals of the
// endpoint ring. buf_flush exists only with USB2_EP_RING_FLUSH_EN defined.
interface usb2_ep_ring_if #(
  parameter int NUM_BUF = 4,
  parameter int BUF_AW  = 9,
  parameter int LEN_W   = BUF_AW + 1
);
  localparam int OCC_W = $clog2(NUM_BUF) + 1;

  logic [BUF_AW-1:0] buf_in_addr;
  logic [7:0]        buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;

  logic [BUF_AW-1:0] buf_out_addr;
  logic [7:0]        buf_out_q;
  logic [LEN_W-1:0]  buf_out_len;
  logic              buf_out_hasdata;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;

  logic [1:0]        mode;
  logic              data_toggle_act;
  logic              data_toggle_clr;
  logic [1:0]        data_toggle;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow;
`ifdef USB2_EP_RING_FLUSH_EN
  logic              buf_flush;
`endif

  modport master (
`ifdef USB2_EP_RING_FLUSH_EN
    output buf_flush,
`endif
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_out_addr, buf_out_arm, mode, data_toggle_act, data_toggle_clr,
    input  buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata,
    input  buf_out_arm_ack, data_toggle, occupancy, overflow
  );

  modport slave (
`ifdef USB2_EP_RING_FLUSH_EN
    input  buf_flush,
`endif
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_out_addr, buf_out_arm, mode, data_toggle_act, data_toggle_clr,
    output buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata,
    output buf_out_arm_ack, data_toggle, occupancy, overflow
  );

endinterface

// File: rtl/usb2_ep_ring_ram.sv
// usb2_ep_ring_ram: simple dual-port byte RAM holding all ring buffers,
// one write port and one synchronous read port. No reset on contents.
module usb2_ep_ring_ram #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [2**AW];
  logic [7:0] r_q;

  // Byte write port.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read: data appears one clock after the address.
  always_ff @(posedge i_clk) begin
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/usb2_ep_ring.sv
// usb2_ep_ring: NUM_BUF-deep ring of 2^BUF_AW-byte packet buffers for one
// USB2 endpoint, with commit/arm handshakes and data-toggle sequencing.
// Define USB2_EP_RING_FLUSH_EN to add the single-cycle buf_flush input.
module usb2_ep_ring
  import usb2_ep_pkg::*;
#(
  parameter int NUM_BUF = 4,
  parameter int BUF_AW  = 9,
  parameter int LEN_W   = BUF_AW + 1
) (
  input logic           phy_clk,
  input logic           reset_n,
  usb2_ep_ring_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_BUF);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(NUM_BUF);

  logic [IDX_W-1:0] r_wr, r_rd;
  logic [OCC_W-1:0] r_occ;
  logic             r_ovf, r_cack, r_aack, r_ready, r_hasdata;
  logic [LEN_W-1:0] r_len_out;
  logic [LEN_W-1:0] r_len [NUM_BUF];
  logic [1:0]       r_tog;

  logic             w_flush, w_arm_ok, w_commit_ok, w_ovf_nxt;
  logic [IDX_W-1:0] w_wr_nxt, w_rd_nxt;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [LEN_W-1:0] w_len_out;

`ifdef USB2_EP_RING_FLUSH_EN
  assign w_flush = bus.buf_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Accept/reject decisions and next pointer state. When full, a same-cycle
  // arm frees the head slot first so the commit can land in it.
  always_comb begin
    w_arm_ok    = bus.buf_out_arm & (r_occ != '0) & ~w_flush;
    w_commit_ok = bus.buf_in_commit & ((r_occ != OCC_FULL) | w_arm_ok) & ~w_flush;
    w_wr_nxt    = r_wr + IDX_W'(w_commit_ok);
    w_rd_nxt    = r_rd + IDX_W'(w_arm_ok);
    w_occ_nxt   = r_occ + OCC_W'(w_commit_ok) - OCC_W'(w_arm_ok);
    w_ovf_nxt   = r_ovf | (bus.buf_in_commit & ~w_commit_ok);
    if (w_flush) begin
      w_rd_nxt  = r_wr;
      w_occ_nxt = '0;
      w_ovf_nxt = 1'b0;
    end
    // A commit into an empty ring becomes the new head in the same edge.
    if (w_commit_ok && (w_rd_nxt == r_wr)) w_len_out = bus.buf_in_commit_len;
    else                                   w_len_out = r_len[w_rd_nxt];
  end

  // Pointers, occupancy, sticky overflow, acks and registered status.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_occ     <= '0;
      r_ovf     <= 1'b0;
      r_cack    <= 1'b0;
      r_aack    <= 1'b0;
      r_ready   <= 1'b1;
      r_hasdata <= 1'b0;
      r_len_out <= '0;
    end else begin
      r_wr      <= w_wr_nxt;
      r_rd      <= w_rd_nxt;
      r_occ     <= w_occ_nxt;
      r_ovf     <= w_ovf_nxt;
      r_cack    <= w_commit_ok;
      r_aack    <= w_arm_ok;
      r_ready   <= (w_occ_nxt != OCC_FULL);
      r_hasdata <= (w_occ_nxt != '0);
      r_len_out <= w_len_out;
    end
  end

  // Per-buffer committed length table.
  always_ff @(posedge phy_clk) begin
    if (w_commit_ok) r_len[r_wr] <= bus.buf_in_commit_len;
  end

  // Data toggle: clear wins over advance; mode only affects the advance rule.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n)                r_tog <= DATA_TOGGLE_0;
    else if (bus.data_toggle_clr) r_tog <= DATA_TOGGLE_0;
    else if (bus.data_toggle_act) r_tog <= next_toggle(r_tog, bus.mode == EP_MODE_ISOCH);
  end

  usb2_ep_ring_ram #(.AW(IDX_W + BUF_AW)) u_ram (
    .i_clk   (phy_clk),
    .i_we    (bus.buf_in_wren),
    .i_waddr ({r_wr, bus.buf_in_addr}),
    .i_wdata (bus.buf_in_data),
    .i_raddr ({r_rd, bus.buf_out_addr}),
    .o_rdata (bus.buf_out_q)
  );

  assign bus.buf_in_ready      = r_ready;
  assign bus.buf_in_commit_ack = r_cack;
  assign bus.buf_out_len       = r_len_out;
  assign bus.buf_out_hasdata   = r_hasdata;
  assign bus.buf_out_arm_ack   = r_aack;
  assign bus.data_toggle       = r_tog;
  assign bus.occupancy         = r_occ;
  assign bus.overflow          = r_ovf;
endmodule

// File: tb/tb_usb2_ep_ring.sv
// tb_usb2_ep_ring: scoreboard bench for usb2_ep_ring. The stimulus side runs a
// queue-based model of the ring and pushes expected acks/status/read data;
// a negedge monitor pops and compares. Flush checks follow USB2_EP_RING_FLUSH_EN.
module tb_usb2_ep_ring;
  import usb2_ep_pkg::*;

  localparam int NB = 4;
  localparam int AW = 9;
  localparam int LW = AW + 1;
  localparam int SZ = 1 << AW;

  logic phy_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 phy_clk = ~phy_clk;

  usb2_ep_ring_if #(.NUM_BUF(NB), .BUF_AW(AW), .LEN_W(LW)) bus ();

  usb2_ep_ring #(.NUM_BUF(NB), .BUF_AW(AW), .LEN_W(LW)) dut (
    .phy_clk (phy_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge phy_clk) cyc <= cyc + 1;

  // Reference model: committed buffers as a queue of lengths, slots as counters.
  logic [7:0] m_mem [NB][SZ];
  bit         m_vld [NB][SZ];
  int         m_lens[$];
  int         m_wr, m_rd, m_tog, m_mode;
  bit         m_ovf;

  typedef struct { int cyc; int occ; bit ovf; int tog; int len; } st_t;
  typedef struct { int cyc; int d; } rd_t;
  int  q_cack[$];
  int  q_aack[$];
  st_t q_st[$];
  rd_t q_rd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the expectation queues.
  always @(negedge phy_clk) begin
    if (reset_n) begin
      bit e;
      while (q_cack.size() > 0 && q_cack[0] < cyc) void'(q_cack.pop_front());
      while (q_aack.size() > 0 && q_aack[0] < cyc) void'(q_aack.pop_front());
      e = (q_cack.size() > 0 && q_cack[0] == cyc);
      chk("commit_ack", bus.buf_in_commit_ack, e);
      if (e) void'(q_cack.pop_front());
      e = (q_aack.size() > 0 && q_aack[0] == cyc);
      chk("arm_ack", bus.buf_out_arm_ack, e);
      if (e) void'(q_aack.pop_front());
      if (q_st.size() > 0 && q_st[0].cyc == cyc) begin
        st_t s;
        s = q_st.pop_front();
        chk("occupancy", bus.occupancy, s.occ);
        chk("buf_in_ready", bus.buf_in_ready, s.occ < NB);
        chk("buf_out_hasdata", bus.buf_out_hasdata, s.occ > 0);
        chk("overflow", bus.overflow, s.ovf);
        chk("data_toggle", bus.data_toggle, s.tog);
        if (s.occ > 0) chk("buf_out_len", bus.buf_out_len, s.len);
      end
      if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
        rd_t r;
        r = q_rd.pop_front();
        chk("buf_out_q", bus.buf_out_q, r.d);
      end
    end
  end

  task automatic model_reset();
    m_lens.delete();
    m_wr = 0; m_rd = 0; m_tog = 0; m_ovf = 0;
    foreach (m_vld[i, j]) m_vld[i][j] = 1'b0;
    q_cack.delete(); q_aack.delete(); q_st.delete(); q_rd.delete();
  endtask

  // One clock of stimulus; model decides expectations for the next edge.
  task automatic tick(input bit c = 0, input int len = 0, input bit a = 0,
                      input bit we = 0, input int wa = 0, input int wd = 0,
                      input bit rchk = 0, input int ra = 0,
                      input bit act = 0, input bit clr = 0, input int md = -1,
                      input bit fl = 0);
    int  ec;
    bit  arm_ok, com_ok;
    ec = cyc + 1;
    if (md >= 0) m_mode = md;
    bus.mode              = 2'(m_mode);
    bus.buf_in_commit     = c;
    bus.buf_in_commit_len = LW'(len);
    bus.buf_out_arm       = a;
    bus.buf_in_wren       = we;
    bus.buf_in_addr       = AW'(wa);
    bus.buf_in_data       = 8'(wd);
    bus.buf_out_addr      = AW'(ra);
    bus.data_toggle_act   = act;
    bus.data_toggle_clr   = clr;
`ifdef USB2_EP_RING_FLUSH_EN
    bus.buf_flush         = fl;
`endif
    if (rchk && m_lens.size() > 0 && m_vld[m_rd][ra]) q_rd.push_back('{ec, int'(m_mem[m_rd][ra])});
    if (we) begin
      m_mem[m_wr][wa] = 8'(wd);
      m_vld[m_wr][wa] = 1'b1;
    end
`ifdef USB2_EP_RING_FLUSH_EN
    if (fl) begin
      m_lens.delete();
      m_rd = m_wr;
      m_ovf = 0;
    end else
`endif
    begin
      arm_ok = a && m_lens.size() > 0;
      com_ok = c && (m_lens.size() < NB || arm_ok);
      if (arm_ok) begin
        void'(m_lens.pop_front());
        m_rd = (m_rd + 1) % NB;
        q_aack.push_back(ec);
      end
      if (com_ok) begin
        m_lens.push_back(len);
        m_wr = (m_wr + 1) % NB;
        q_cack.push_back(ec);
      end else if (c) begin
        m_ovf = 1;
      end
    end
    if (clr) m_tog = 0;
    else if (act) begin
      if (m_mode == 1) m_tog = (m_tog + 1) % 3;
      else             m_tog = (m_tog == 0) ? 1 : 0;
    end
    q_st.push_back('{ec, m_lens.size(), m_ovf, m_tog, (m_lens.size() > 0) ? m_lens[0] : 0});
    @(posedge phy_clk);
    #1;
    bus.buf_in_commit = 0; bus.buf_out_arm = 0; bus.buf_in_wren = 0;
    bus.data_toggle_act = 0; bus.data_toggle_clr = 0;
`ifdef USB2_EP_RING_FLUSH_EN
    bus.buf_flush = 0;
`endif
  endtask

  task automatic check_reset_values();
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_ready", bus.buf_in_ready, 1);
    chk("rst_hasdata", bus.buf_out_hasdata, 0);
    chk("rst_len", bus.buf_out_len, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_toggle", bus.data_toggle, 0);
    chk("rst_commit_ack", bus.buf_in_commit_ack, 0);
    chk("rst_arm_ack", bus.buf_out_arm_ack, 0);
  endtask

  // Asynchronous reset applied between edges; values checked before any clock.
  task automatic mid_reset();
    @(negedge phy_clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge phy_clk);
    @(negedge phy_clk);
    #2;
    reset_n = 1'b1;
    @(posedge phy_clk);
    #1;
  endtask

  initial begin
    bus.buf_in_addr = '0; bus.buf_in_data = '0; bus.buf_in_wren = 0;
    bus.buf_in_commit = 0; bus.buf_in_commit_len = '0;
    bus.buf_out_addr = '0; bus.buf_out_arm = 0; bus.mode = 2'd0;
    bus.data_toggle_act = 0; bus.data_toggle_clr = 0;
`ifdef USB2_EP_RING_FLUSH_EN
    bus.buf_flush = 0;
`endif
    m_mode = 0;
    model_reset();
    repeat (2) @(posedge phy_clk);
    #1;
    check_reset_values();
    @(negedge phy_clk);
    #2;
    reset_n = 1'b1;
    @(posedge phy_clk);
    #1;

    // 64-byte packet: write, commit, read back, release.
    for (int i = 0; i < 64; i++) tick(.we(1), .wa(i), .wd($urandom_range(0, 255)));
    tick(.c(1), .len(64));
    tick();
    for (int i = 0; i < 64; i++) tick(.rchk(1), .ra(i));
    tick(.a(1));
    tick(.a(1));   // arm on empty: no ack

    // Fill, then a fifth commit overflows.
    for (int i = 0; i < 5; i++) tick(.c(1), .len($urandom_range(1, SZ)));
    tick(.c(1), .a(1), .len(77));   // full: arm first, commit accepted
    tick(.act(1));
    tick(.a(1));
    mid_reset();                    // occupancy 3, overflow and toggle set

    // Simultaneous commit and arm at occupancy 2.
    tick(.c(1), .len(11));
    tick(.c(1), .len(22));
    tick(.c(1), .a(1), .len(33));
    tick();
    tick(.c(1), .a(1), .len(44));   // empty-ish case handled by the model too
    repeat (3) tick(.a(1));
    tick(.c(1), .a(1), .len(55));   // empty: only the commit
    tick(.a(1));

    // Eight commit/arm pairs wrap both pointers.
    for (int i = 0; i < 8; i++) begin
      tick(.c(1), .len(100 + i));
      tick(.a(1));
    end

    // Toggle sequencing.
    tick(.md(1));
    repeat (4) tick(.act(1));
    tick(.md(2), .act(1));
    tick(.md(1), .act(1));
    tick(.act(1));                  // isoch reaches 2
    tick(.md(2));                   // mode change keeps 2
    tick(.act(1));                  // non-isoch 2 -> 0
    tick(.act(1));
    tick(.act(1), .clr(1));

`ifdef USB2_EP_RING_FLUSH_EN
    repeat (3) tick(.c(1), .len($urandom_range(0, SZ)));
    tick(.fl(1), .c(1), .a(1), .len(9));
    tick();
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit c, a, we, fl;
      c  = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 2) == 0);
      we = (m_lens.size() < NB) && ($urandom_range(0, 1) == 1);
      fl = 0;
`ifdef USB2_EP_RING_FLUSH_EN
      fl = ($urandom_range(0, 40) == 0);
`endif
      tick(.c(c), .len($urandom_range(0, SZ)), .a(a),
           .we(we), .wa($urandom_range(0, 15)), .wd($urandom_range(0, 255)),
           .rchk(1), .ra($urandom_range(0, 15)),
           .act($urandom_range(0, 3) == 0), .clr($urandom_range(0, 15) == 0),
           .md(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1),
           .fl(fl));
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
